apb_master: RTL

//   APB requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_master.sv | 128 ++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_state_e;

   localparam int APB_ADDR_W_DEF = 8;
   localparam int APB_DATA_W_DEF = 8;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into SETUP/ACCESS transfers and returns one response per command.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W_DEF,
   parameter int DATA_W         = APB_DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   apb_state_e state;
   apb_state_e state_next;
   logic       started;
   logic       accept;
   logic       done;
   logic       timeout;

   // Holds cmd_ready low until the first clock after reset release.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         started <= 1'b0;
      end else begin
         started <= 1'b1;
      end
   end

   // A response being consumed this cycle frees the slot, so back-to-back accepts are 3 cycles apart.
   assign cmd_ready = started && (state == APB_IDLE) && (!rsp_valid || rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign done      = (state == APB_ACCESS) && (PREADY || timeout);

`ifdef APB_MASTER_TIMEOUT_EN
   logic [7:0] wait_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= 8'd0;
      end else if (state == APB_SETUP) begin
         wait_cnt <= 8'd0;
      end else if ((state == APB_ACCESS) && !PREADY) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
   assign timeout = (state == APB_ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= APB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         APB_IDLE:   if (accept) state_next = APB_SETUP;
         APB_SETUP:  state_next = APB_ACCESS;
         APB_ACCESS: if (done) state_next = APB_IDLE;
         default:    state_next = APB_IDLE;
      endcase
   end

   always_comb begin
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      case (state)
         APB_SETUP:  PSEL = 1'b1;
         APB_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         default: ;
      endcase
   end

   // Bus fields are captured on accept and held through and after the transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
      end else if (accept) begin
         PWRITE <= cmd_write;
         PADDR  <= cmd_addr;
         PWDATA <= cmd_wdata;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (done) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= (PWRITE || timeout) ? '0 : PRDATA;
         rsp_err   <= timeout;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule : apb_master
